// File: rtl/pic_pkg.sv
// -----------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the PIC interrupt acknowledge path.
//   state_t / STATE_*        : acknowledge sequencer FSM encoding
//   DEFAULT_SPURIOUS_LEVEL   : level reported in the vector when nothing was
//                              pending at the first INTA pulse
//   highest_priority_level() : index of the lowest set bit (IR0 = highest)
//   level_to_onehot()        : 3-bit level to 8-bit one-hot
// -----------------------------------------------------------------------------
package pic_pkg;

   typedef logic [1:0] state_t;

   localparam state_t STATE_IDLE  = 2'd0;
   localparam state_t STATE_ACK1  = 2'd1;
   localparam state_t STATE_WAIT2 = 2'd2;
   localparam state_t STATE_ACK2  = 2'd3;

   localparam logic [2:0] DEFAULT_SPURIOUS_LEVEL = 3'd7;

   // Fixed priority: bit 0 wins. Returns 0 when no bit is set, so callers
   // must qualify the result with a separate "any bit set" test.
   function automatic logic [2:0] highest_priority_level(input logic [7:0] bits);
      logic [2:0] level;
      level = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (bits[i]) level = 3'(i);
      end
      return level;
   endfunction

   function automatic logic [7:0] level_to_onehot(input logic [2:0] level);
      return 8'b0000_0001 << level;
   endfunction

endpackage

// File: rtl/priority_resolver.sv
// -----------------------------------------------------------------------------
// priority_resolver
// Combinational fully nested priority resolution.
//   request               in  8  interrupt request register (bit0 = IR0)
//   mask                  in  8  1 = masked
//   in_service_register   in  8  current ISR
//   valid                 out 1  at least one eligible request
//   level                 out 3  highest-priority eligible level (0 if !valid)
// A request is eligible when unmasked and strictly higher priority than the
// highest in-service level.
// -----------------------------------------------------------------------------
module priority_resolver
   import pic_pkg::*;
(
   input  logic [7:0] request,
   input  logic [7:0] mask,
   input  logic [7:0] in_service_register,
   output logic       valid,
   output logic [2:0] level
);

   logic [7:0] allowed;
   logic [7:0] eligible;

   always_comb begin
      allowed = 8'hFF;
      // onehot(n) - 1 leaves exactly the bits of higher priority than level n.
      if (|in_service_register) begin
         allowed = level_to_onehot(highest_priority_level(in_service_register)) - 8'd1;
      end
      eligible = request & ~mask & allowed;
      valid    = |eligible;
      level    = highest_priority_level(eligible);
   end

endmodule

// File: rtl/interrupt_acknowledge_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_acknowledge_sequencer
// CPU-facing end of the PIC: raises INT, runs the 8086 two-pulse INTA
// sequence and owns the in-service register.
//   clock                              in   system clock
//   write_initial_command_word_1_reset in   synchronous active-high reset
//   interrupt_request_register         in 8 IRR (bit0 = IR0)
//   interrupt_mask                     in 8 OCW1 mask, 1 = masked
//   interrupt_acknowledge_n            in   INTA, active low, synchronised
//   vector_base                        in 5 ICW2 T7..T3
//   auto_eoi_config                    in   clear ISR bit at end of 2nd INTA
//   end_of_interrupt                   in   non-specific EOI pulse
//   specific_end_of_interrupt          in   specific EOI pulse
//   end_of_interrupt_level             in 3 level for specific EOI
//   interrupt_to_cpu                   out  INT
//   freeze                             out  hold IRR during acknowledge
//   clear_interrupt_request            out 8 one-hot one-cycle IRR clear
//   in_service_register                out 8 ISR
//   data_out                           out 8 vector byte
//   data_out_enable                    out  drive data bus
//
// INTA handshake: the CPU marks each acknowledge pulse by a falling edge of
// interrupt_acknowledge_n and ends it by the rising edge. IDLE accepts only a
// fall (pulse 1), ACK1 only a rise, WAIT2 only a fall (pulse 2) and ACK2 only
// a rise; any other edge is ignored. The vector is driven only during pulse 2.
// -----------------------------------------------------------------------------
module interrupt_acknowledge_sequencer
   import pic_pkg::*;
#(
   parameter logic [2:0] SPURIOUS_LEVEL = DEFAULT_SPURIOUS_LEVEL
) (
   input  logic       clock,
   input  logic       write_initial_command_word_1_reset,
   input  logic [7:0] interrupt_request_register,
   input  logic [7:0] interrupt_mask,
   input  logic       interrupt_acknowledge_n,
   input  logic [4:0] vector_base,
   input  logic       auto_eoi_config,
   input  logic       end_of_interrupt,
   input  logic       specific_end_of_interrupt,
   input  logic [2:0] end_of_interrupt_level,
   output logic       interrupt_to_cpu,
   output logic       freeze,
   output logic [7:0] clear_interrupt_request,
   output logic [7:0] in_service_register,
   output logic [7:0] data_out,
   output logic       data_out_enable
);

   state_t     state;
   logic       inta_n_q;
   logic [2:0] level_q;
   logic       spurious_q;

   logic       eligible_valid;
   logic [2:0] eligible_level;
   logic       inta_fall;
   logic       inta_rise;
   logic       first_ack;
   logic       second_end;
   logic [7:0] isr_next;

   priority_resolver u_priority_resolver (
      .request             (interrupt_request_register),
      .mask                (interrupt_mask),
      .in_service_register (in_service_register),
      .valid               (eligible_valid),
      .level               (eligible_level)
   );

   assign inta_fall  = inta_n_q & ~interrupt_acknowledge_n;
   assign inta_rise  = ~inta_n_q & interrupt_acknowledge_n;
   assign first_ack  = (state == STATE_IDLE) && inta_fall;
   assign second_end = (state == STATE_ACK2) && inta_rise;

   // EOI works on the pre-edge ISR; a set from the first INTA is applied last
   // so it wins for its own bit.
   always_comb begin
      isr_next = in_service_register;
      if (specific_end_of_interrupt) begin
         isr_next[end_of_interrupt_level] = 1'b0;
      end else if (end_of_interrupt && (|in_service_register)) begin
         isr_next[highest_priority_level(in_service_register)] = 1'b0;
      end
      if (second_end && auto_eoi_config && !spurious_q) begin
         isr_next[level_q] = 1'b0;
      end
      if (first_ack && eligible_valid) begin
         isr_next[eligible_level] = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (write_initial_command_word_1_reset) begin
         state                   <= STATE_IDLE;
         inta_n_q                <= 1'b1;
         level_q                 <= 3'd0;
         spurious_q              <= 1'b0;
         interrupt_to_cpu        <= 1'b0;
         freeze                  <= 1'b0;
         clear_interrupt_request <= 8'h00;
         in_service_register     <= 8'h00;
         data_out                <= 8'h00;
         data_out_enable         <= 1'b0;
      end else begin
         inta_n_q                <= interrupt_acknowledge_n;
         in_service_register     <= isr_next;
         clear_interrupt_request <= 8'h00;
         // INT follows eligibility only while idle and drops on pulse 1.
         interrupt_to_cpu        <= (state == STATE_IDLE) && !inta_fall && eligible_valid;

         case (state)
            STATE_IDLE: begin
               if (inta_fall) begin
                  state      <= STATE_ACK1;
                  level_q    <= eligible_level;
                  spurious_q <= ~eligible_valid;
                  freeze     <= 1'b1;
                  if (eligible_valid) begin
                     clear_interrupt_request <= level_to_onehot(eligible_level);
                  end
               end
            end
            STATE_ACK1: begin
               if (inta_rise) state <= STATE_WAIT2;
            end
            STATE_WAIT2: begin
               if (inta_fall) begin
                  state           <= STATE_ACK2;
                  data_out        <= {vector_base, spurious_q ? SPURIOUS_LEVEL : level_q};
                  data_out_enable <= 1'b1;
               end
            end
            default: begin
               if (inta_rise) begin
                  state           <= STATE_IDLE;
                  data_out_enable <= 1'b0;
                  freeze          <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_interrupt_acknowledge_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_acknowledge_sequencer
// Directed bench: a per-cycle vector table for reset, basic acknowledge and
// nesting, then hand-written sequences for spurious, auto-EOI, EOI ordering
// and reset in the middle of an acknowledge.
// -----------------------------------------------------------------------------
module tb_interrupt_acknowledge_sequencer;

   logic       clock = 1'b0;
   logic       rst;
   logic [7:0] irr;
   logic [7:0] mask;
   logic       inta_n;
   logic [4:0] vb;
   logic       aeoi;
   logic       eoi;
   logic       seoi;
   logic [2:0] eoi_lvl;
   logic       int_o;
   logic       frz_o;
   logic [7:0] clr_o;
   logic [7:0] isr_o;
   logic [7:0] dout_o;
   logic       oe_o;

   int checks = 0;
   int errors = 0;

   // clock
   always #5 clock = ~clock;

   interrupt_acknowledge_sequencer dut (
      .clock                              (clock),
      .write_initial_command_word_1_reset (rst),
      .interrupt_request_register         (irr),
      .interrupt_mask                     (mask),
      .interrupt_acknowledge_n            (inta_n),
      .vector_base                        (vb),
      .auto_eoi_config                    (aeoi),
      .end_of_interrupt                   (eoi),
      .specific_end_of_interrupt          (seoi),
      .end_of_interrupt_level             (eoi_lvl),
      .interrupt_to_cpu                   (int_o),
      .freeze                             (frz_o),
      .clear_interrupt_request            (clr_o),
      .in_service_register                (isr_o),
      .data_out                           (dout_o),
      .data_out_enable                    (oe_o)
   );

   typedef struct packed {
      logic       rst;
      logic [7:0] irr;
      logic       inta_n;
      logic       e_int;
      logic       e_frz;
      logic [7:0] e_clr;
      logic [7:0] e_isr;
      logic [7:0] e_dout;
      logic       e_oe;
   } vec_t;

   vec_t table_q[$];

   task automatic add(input logic r, input logic [7:0] i, input logic a,
                      input logic ei, input logic ef, input logic [7:0] ec,
                      input logic [7:0] es, input logic [7:0] ed, input logic eo);
      vec_t v;
      v = '{rst: r, irr: i, inta_n: a, e_int: ei, e_frz: ef, e_clr: ec,
            e_isr: es, e_dout: ed, e_oe: eo};
      table_q.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic expect_all(input string name, input logic ei, input logic ef,
                             input logic [7:0] ec, input logic [7:0] es,
                             input logic [7:0] ed, input logic eo);
      check({name, ".int"},  {7'd0, int_o}, {7'd0, ei});
      check({name, ".frz"},  {7'd0, frz_o}, {7'd0, ef});
      check({name, ".clr"},  clr_o, ec);
      check({name, ".isr"},  isr_o, es);
      check({name, ".dout"}, dout_o, ed);
      check({name, ".oe"},   {7'd0, oe_o}, {7'd0, eo});
   endtask

   // driver: apply irr/inta_n, clock once, sample 1 time unit after the edge
   task automatic cyc(input string name, input logic [7:0] i, input logic a,
                      input logic ei, input logic ef, input logic [7:0] ec,
                      input logic [7:0] es, input logic [7:0] ed, input logic eo);
      irr    = i;
      inta_n = a;
      @(posedge clock);
      #1;
      expect_all(name, ei, ef, ec, es, ed, eo);
   endtask

   initial begin
      rst = 1'b1; irr = 8'hFF; mask = 8'h00; inta_n = 1'b1; vb = 5'h08;
      aeoi = 1'b0; eoi = 1'b0; seoi = 1'b0; eoi_lvl = 3'd0;

      //   rst irr    inta int frz clr    isr    dout   oe
      add(1, 8'hFF, 1,   0,  0,  8'h00, 8'h00, 8'h00, 0);  // reset with IRR=FF
      add(1, 8'hFF, 1,   0,  0,  8'h00, 8'h00, 8'h00, 0);
      add(0, 8'hFF, 1,   1,  0,  8'h00, 8'h00, 8'h00, 0);  // INT one cycle after release
      add(0, 8'h04, 1,   1,  0,  8'h00, 8'h00, 8'h00, 0);
      add(0, 8'h04, 0,   0,  1,  8'h04, 8'h04, 8'h00, 0);  // first INTA fall
      add(0, 8'h01, 0,   0,  1,  8'h00, 8'h04, 8'h00, 0);  // IRR change while frozen
      add(0, 8'h01, 1,   0,  1,  8'h00, 8'h04, 8'h00, 0);  // rise -> WAIT2
      add(0, 8'h01, 1,   0,  1,  8'h00, 8'h04, 8'h00, 0);
      add(0, 8'h01, 0,   0,  1,  8'h00, 8'h04, 8'h42, 1);  // second INTA: vector
      add(0, 8'h01, 0,   0,  1,  8'h00, 8'h04, 8'h42, 1);
      add(0, 8'h08, 1,   0,  0,  8'h00, 8'h04, 8'h42, 0);  // end of sequence
      add(0, 8'h08, 1,   0,  0,  8'h00, 8'h04, 8'h42, 0);  // IR3 below in-service IR2
      add(0, 8'h08, 1,   0,  0,  8'h00, 8'h04, 8'h42, 0);
      add(0, 8'h09, 1,   1,  0,  8'h00, 8'h04, 8'h42, 0);  // IR0 nests
      add(0, 8'h09, 0,   0,  1,  8'h01, 8'h05, 8'h42, 0);
      add(0, 8'h08, 1,   0,  1,  8'h00, 8'h05, 8'h42, 0);
      add(0, 8'h08, 0,   0,  1,  8'h00, 8'h05, 8'h40, 1);
      add(0, 8'h08, 1,   0,  0,  8'h00, 8'h05, 8'h40, 0);

      for (int k = 0; k < table_q.size(); k++) begin
         rst = table_q[k].rst;
         cyc($sformatf("vec%0d", k), table_q[k].irr, table_q[k].inta_n,
             table_q[k].e_int, table_q[k].e_frz, table_q[k].e_clr,
             table_q[k].e_isr, table_q[k].e_dout, table_q[k].e_oe);
      end

      // non-specific then specific EOI
      eoi = 1'b1;
      cyc("eoi_ns", 8'h00, 1, 0, 0, 8'h00, 8'h04, 8'h40, 0);
      eoi = 1'b0; seoi = 1'b1; eoi_lvl = 3'd2;
      cyc("eoi_sp", 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h40, 0);
      seoi = 1'b0;

      // mask gates INT
      mask = 8'h01;
      cyc("masked", 8'h01, 1, 0, 0, 8'h00, 8'h00, 8'h40, 0);
      mask = 8'h00;
      cyc("unmask", 8'h01, 1, 1, 0, 8'h00, 8'h00, 8'h40, 0);

      // spurious: request gone at the first fall
      cyc("spur_f1", 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h40, 0);
      cyc("spur_r1", 8'h00, 1, 0, 1, 8'h00, 8'h00, 8'h40, 0);
      cyc("spur_f2", 8'h00, 0, 0, 1, 8'h00, 8'h00, 8'h47, 1);
      cyc("spur_r2", 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h47, 0);

      // auto-EOI on IR5
      aeoi = 1'b1;
      cyc("aeoi_req", 8'h20, 1, 1, 0, 8'h00, 8'h00, 8'h47, 0);
      cyc("aeoi_f1",  8'h20, 0, 0, 1, 8'h20, 8'h20, 8'h47, 0);
      cyc("aeoi_r1",  8'h00, 1, 0, 1, 8'h00, 8'h20, 8'h47, 0);
      cyc("aeoi_f2",  8'h00, 0, 0, 1, 8'h00, 8'h20, 8'h45, 1);
      cyc("aeoi_r2",  8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h45, 0);
      aeoi = 1'b0;

      // build ISR=0A, then both EOI pulses: specific (level 3) wins
      cyc("ir3_req", 8'h08, 1, 1, 0, 8'h00, 8'h00, 8'h45, 0);
      cyc("ir3_f1",  8'h08, 0, 0, 1, 8'h08, 8'h08, 8'h45, 0);
      cyc("ir3_r1",  8'h00, 1, 0, 1, 8'h00, 8'h08, 8'h45, 0);
      cyc("ir3_f2",  8'h00, 0, 0, 1, 8'h00, 8'h08, 8'h43, 1);
      cyc("ir3_r2",  8'h00, 1, 0, 0, 8'h00, 8'h08, 8'h43, 0);
      cyc("ir1_req", 8'h02, 1, 1, 0, 8'h00, 8'h08, 8'h43, 0);
      cyc("ir1_f1",  8'h02, 0, 0, 1, 8'h02, 8'h0A, 8'h43, 0);
      cyc("ir1_r1",  8'h00, 1, 0, 1, 8'h00, 8'h0A, 8'h43, 0);
      cyc("ir1_f2",  8'h00, 0, 0, 1, 8'h00, 8'h0A, 8'h41, 1);
      cyc("ir1_r2",  8'h00, 1, 0, 0, 8'h00, 8'h0A, 8'h41, 0);
      eoi = 1'b1; seoi = 1'b1; eoi_lvl = 3'd3;
      cyc("eoi_both", 8'h00, 1, 0, 0, 8'h00, 8'h02, 8'h41, 0);
      eoi = 1'b0; seoi = 1'b0;

      // EOI of IR1 and ISR set of IR0 on the same edge
      cyc("same_req", 8'h01, 1, 1, 0, 8'h00, 8'h02, 8'h41, 0);
      eoi = 1'b1;
      cyc("same_f1",  8'h01, 0, 0, 1, 8'h01, 8'h01, 8'h41, 0);
      eoi = 1'b0;
      cyc("same_r1",  8'h00, 1, 0, 1, 8'h00, 8'h01, 8'h41, 0);
      cyc("same_f2",  8'h00, 0, 0, 1, 8'h00, 8'h01, 8'h40, 1);
      cyc("same_r2",  8'h00, 1, 0, 0, 8'h00, 8'h01, 8'h40, 0);

      // reset while in WAIT2
      cyc("rst_f1", 8'h00, 0, 0, 1, 8'h00, 8'h01, 8'h40, 0);
      cyc("rst_r1", 8'h00, 1, 0, 1, 8'h00, 8'h01, 8'h40, 0);
      rst = 1'b1;
      cyc("rst_mid", 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0);
      rst = 1'b0;
      cyc("rst_idle", 8'h00, 1, 0, 0, 8'h00, 8'h00, 8'h00, 0);
      cyc("post_req", 8'h01, 1, 1, 0, 8'h00, 8'h00, 8'h00, 0);
      cyc("post_f1",  8'h01, 0, 0, 1, 8'h01, 8'h01, 8'h00, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
